// File: rtl/intlv_block_feeder.sv
// -----------------------------------------------------------------------------
// intlv_block_feeder
//
// Purpose:
//   Sits between the code-block-segmentation (CBS) byte stream and the
//   interleaver. It accepts one code block as a valid/ready byte stream
//   (132 bytes for K=1056, 768 bytes for K=6144) and forwards each byte on the
//   interleaver's byte-shift interface. It then holds the interleaver's
//   ready_in high for exactly K cycles. CBS is back-pressured until the block
//   has fully drained, so only one block is in flight at a time.
//
// Sequence of states: IDLE -> LOAD -> GAP -> DRAIN -> DONE -> IDLE
//
// Ports:
//   clock        in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   cbs_byte     in   [7:0] data byte from CBS
//   cbs_valid    in   cbs_byte is valid
//   cbs_k6144    in   block size of the current block (1 = 6144, 0 = 1056)
//   cbs_ready    out  feeder can accept a byte (IDLE or LOAD, not in reset)
//   k_size_6144  out  latched block size, to the interleaver
//   databyte_out out  [7:0] byte to the interleaver shift register
//   shift_en     out  one-cycle shift strobe per forwarded byte
//   ready_out    out  interleaver ready_in, high for exactly K cycles
//   busy         out  block in progress (any state other than IDLE)
//   block_done   out  one-cycle pulse at the end of a block
//   blk_count    out  [15:0] completed-block counter
//
// Optional feature (compile-time macro INTLV_FEEDER_BLKCNT_EN):
//   defined     - blk_count counts DONE cycles, cleared by rst, wraps at 16 bits
//   not defined - blk_count is tied to zero and no counter exists
// -----------------------------------------------------------------------------
module intlv_block_feeder #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int CNT_W   = 14
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [7:0]  cbs_byte,
  input  logic        cbs_valid,
  input  logic        cbs_k6144,
  output logic        cbs_ready,
  output logic        k_size_6144,
  output logic [7:0]  databyte_out,
  output logic        shift_en,
  output logic        ready_out,
  output logic        busy,
  output logic        block_done,
  output logic [15:0] blk_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] byte_cnt_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] nbytes;
  logic [CNT_W-1:0] last_bit;
  logic             accept;

  // NOTE: cbs_ready is gated by rst so that no byte can be taken on the reset
  // edge itself, regardless of what state the register holds before reset.
  assign cbs_ready = !rst && ((state == S_IDLE) || (state == S_LOAD));
  assign accept    = cbs_valid && cbs_ready;

  // Block geometry follows the latched size, so a mid-block change on
  // cbs_k6144 cannot alter the byte count or drain length.
  assign nbytes   = k_size_6144 ? CNT_W'(K_LARGE / 8) : CNT_W'(K_SMALL / 8);
  assign last_bit = k_size_6144 ? CNT_W'(K_LARGE - 1) : CNT_W'(K_SMALL - 1);

  assign byte_cnt_nxt = byte_cnt + CNT_ONE;

  // Status outputs are pure decodes of the state register.
  assign ready_out  = (state == S_DRAIN);
  assign busy       = (state != S_IDLE);
  assign block_done = (state == S_DONE);

  // NOTE: every register here is written with non-blocking assignments so
  // that all state updates see the pre-edge values of their neighbours.
  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      bit_cnt      <= '0;
      k_size_6144  <= 1'b0;
      databyte_out <= 8'h00;
      shift_en     <= 1'b0;
    end else begin
      // Byte path: one registered stage; databyte_out holds between strobes.
      shift_en <= accept;
      if (accept) begin
        databyte_out <= cbs_byte;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            k_size_6144 <= cbs_k6144;
            byte_cnt    <= CNT_ONE;
            state       <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt_nxt;
            if (byte_cnt_nxt == nbytes) begin
              state <= S_GAP;
            end
          end
        end

        // The final shift_en is visible during this cycle; the drain counter
        // is primed so DRAIN starts at bit 0.
        S_GAP: begin
          bit_cnt <= '0;
          state   <= S_DRAIN;
        end

        S_DRAIN: begin
          if (bit_cnt == last_bit) begin
            state <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef INTLV_FEEDER_BLKCNT_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      blk_count <= 16'h0000;
    end else if (state == S_DONE) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`else
  assign blk_count = 16'h0000;
`endif

endmodule
